seg_dynamic_scan: RTL and testbench

//  Multiplexed N-digit 7-segment driver, the scanned successor to the static driver. Shows a hex

---
 rtl/seg_dynamic_scan.sv | 207 ++++++++++++++++++++
 tb/tb_seg_dynamic_scan.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_dynamic_scan.sv
// Multiplexed N-digit hex 7-segment scanner with per-slot blanking gap,
// frame-boundary double buffering and optional leading-zero suppression.
module seg_dynamic_scan #(
  parameter int DIGITS      = 6,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int SEL_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF   = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  // True when idx is not the rightmost digit and it and every digit to its left are zero.
  function automatic logic leading_zero(input logic [4*DIGITS-1:0] word,
                                        input logic [IDX_W-1:0]    idx);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_zero = all_zero & ((i < int'(idx)) | (word[4*i +: 4] == 4'h0));
    end
    return (idx != {IDX_W{1'b0}}) & all_zero;
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic                fs_armed_q, fs_armed_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_start_q, frame_start_d;

  phase_e              phase_s;
  logic                slot_end_s;
  logic                frame_end_s;
  logic                first_drive_s;
  logic [3:0]          nib_s;
  logic [7:0]          lit_s;

  if (BLANK_CYC == 0) begin : g_no_blank
    assign phase_s = PH_DRIVE;
  end else begin : g_blank
    assign phase_s = (cnt_q < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
  end

  assign slot_end_s    = (cnt_q == CNT_LAST);
  assign frame_end_s   = slot_end_s & (idx_q == IDX_LAST);
  assign first_drive_s = (cnt_q == CNT_BLANK) & (idx_q == {IDX_W{1'b0}});

  // Scan timing, buffer handover and frame_start arming.
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pend_valid_d  = pend_valid_q;
    fs_armed_d    = fs_armed_q;
    frame_start_d = 1'b0;

    if (slot_end_s) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (fs_armed_q && first_drive_s) begin
      frame_start_d = 1'b1;
      fs_armed_d    = 1'b0;
    end else begin
      frame_start_d = 1'b0;
    end

    // A load coinciding with frame_end bypasses the pending buffer.
    if (frame_end_s) begin
      if (load) begin
        shadow_data_d = data;
        shadow_dp_d   = dp;
        pend_valid_d  = 1'b0;
        fs_armed_d    = 1'b1;
      end else if (pend_valid_q) begin
        shadow_data_d = pend_data_q;
        shadow_dp_d   = pend_dp_q;
        pend_valid_d  = 1'b0;
        fs_armed_d    = 1'b1;
      end else begin
        shadow_data_d = shadow_data_q;
      end
    end else if (load) begin
      pend_data_d  = data;
      pend_dp_d    = dp;
      pend_valid_d = 1'b1;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Next sel/seg image from the current slot phase and shadow digit.
  always_comb begin
    nib_s = shadow_data_q[4*int'(idx_q) +: 4];
    lit_s = {shadow_dp_q[idx_q],
             leading_zero(shadow_data_q, idx_q) & lz_blank ? 7'h00 : hex_decode(nib_s)};
    case (phase_s)
      PH_DRIVE: begin
        sel_d = SEL_OFF ^ (DIGITS'(1'b1) << idx_q);
        seg_d = lit_s ^ SEG_OFF;
      end
      PH_BLANK: begin
        sel_d = SEL_OFF;
        seg_d = SEG_OFF;
      end
      default: begin
        sel_d = SEL_OFF;
        seg_d = SEG_OFF;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= {CNT_W{1'b0}};
      idx_q         <= {IDX_W{1'b0}};
      shadow_data_q <= {(4*DIGITS){1'b0}};
      shadow_dp_q   <= {DIGITS{1'b0}};
      pend_data_q   <= {(4*DIGITS){1'b0}};
      pend_dp_q     <= {DIGITS{1'b0}};
      pend_valid_q  <= 1'b0;
      fs_armed_q    <= 1'b0;
      sel_q         <= SEL_OFF;
      seg_q         <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      fs_armed_q    <= fs_armed_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sel         = sel_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Bench for seg_dynamic_scan: two instances (BLANK_CYC=2 and 0) share stimulus and are
// checked every cycle against a time-indexed model, plus literal directed expectations.
module tb_seg_dynamic_scan;

  localparam int D     = 4;
  localparam int SD    = 8;
  localparam int FRAME = D * SD;

  localparam logic [6:0] TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [3:0]  sel_a, sel_b;
  logic [7:0]  seg_a, seg_b;
  logic        fs_a, fs_b;

  int n_checks = 0;
  int n_errors = 0;

  // model state per instance (0: BLANK_CYC=2, 1: BLANK_CYC=0)
  int          m_t     [2];
  logic [15:0] m_sh_d  [2];
  logic [3:0]  m_sh_dp [2];
  logic [15:0] m_pd_d  [2];
  logic [3:0]  m_pd_dp [2];
  bit          m_pv    [2];
  bit          m_arm   [2];
  logic [3:0]  exp_sel [2];
  logic [7:0]  exp_seg [2];
  logic        exp_fs  [2];

  always #5 clk = ~clk;

  seg_dynamic_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(2), .SEL_ACT_LOW(1), .SEG_ACT_LOW(1))
    u_dut_a (.clk(clk), .rst(rst), .data(data), .dp(dp), .load(load), .lz_blank(lz_blank),
             .sel(sel_a), .seg(seg_a), .frame_start(fs_a));

  seg_dynamic_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(0), .SEL_ACT_LOW(1), .SEG_ACT_LOW(1))
    u_dut_b (.clk(clk), .rst(rst), .data(data), .dp(dp), .load(load), .lz_blank(lz_blank),
             .sel(sel_b), .seg(seg_b), .frame_start(fs_b));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_t[k] = 0; m_sh_d[k] = 16'h0; m_sh_dp[k] = 4'h0; m_pv[k] = 1'b0; m_arm[k] = 1'b0;
    exp_sel[k] = 4'hF; exp_seg[k] = 8'hFF; exp_fs[k] = 1'b0;
  endtask

  // Outputs follow from the elapsed cycle count since reset and the displayed word.
  task automatic model_step(input int k);
    int         bc, cnt, idx;
    logic [3:0] nib;
    logic       blank;
    logic [7:0] lit;
    bc  = (k == 0) ? 2 : 0;
    cnt = m_t[k] % SD;
    idx = (m_t[k] / SD) % D;
    if (cnt < bc) begin
      exp_sel[k] = 4'hF;
      exp_seg[k] = 8'hFF;
    end else begin
      exp_sel[k] = ~(4'b0001 << idx);
      nib   = 4'(m_sh_d[k] >> (4 * idx));
      blank = lz_blank && (idx != 0) && ((m_sh_d[k] >> (4 * idx)) == 16'h0);
      lit   = {m_sh_dp[k][idx], blank ? 7'h00 : TAB[nib]};
      exp_seg[k] = ~lit;
    end
    exp_fs[k] = m_arm[k] && (cnt == bc) && (idx == 0);
    if (exp_fs[k]) m_arm[k] = 1'b0;
    if (cnt == SD - 1 && idx == D - 1) begin
      if (load) begin
        m_sh_d[k] = data; m_sh_dp[k] = dp; m_pv[k] = 1'b0; m_arm[k] = 1'b1;
      end else if (m_pv[k]) begin
        m_sh_d[k] = m_pd_d[k]; m_sh_dp[k] = m_pd_dp[k]; m_pv[k] = 1'b0; m_arm[k] = 1'b1;
      end
    end else if (load) begin
      m_pd_d[k] = data; m_pd_dp[k] = dp; m_pv[k] = 1'b1;
    end
    m_t[k]++;
  endtask

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      else     model_step(k);
    end
    #1;
    chk("sel_a", {4'h0, sel_a}, {4'h0, exp_sel[0]});
    chk("seg_a", seg_a, exp_seg[0]);
    chk("fs_a",  {7'h0, fs_a}, {7'h0, exp_fs[0]});
    chk("sel_b", {4'h0, sel_b}, {4'h0, exp_sel[1]});
    chk("seg_b", seg_b, exp_seg[1]);
    chk("fs_b",  {7'h0, fs_b}, {7'h0, exp_fs[1]});
  end

  task automatic skip(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    data = d; dp = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fs(input int which, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if ((which == 0 ? fs_a : fs_b) === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: frame_start got none expected pulse within 100 cycles", name);
    end
  endtask

  task automatic count_fs_a(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (fs_a === 1'b1) c++;
    end
  endtask

  initial begin
    int  c;
    bit  found;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // release: two blank cycles then digit 0 driven
    skip(1); chk("t1 c1 sel", {4'h0, sel_a}, 8'h0F);
    skip(1); chk("t1 c2 sel", {4'h0, sel_a}, 8'h0F);
    skip(1); chk("t1 c3 sel", {4'h0, sel_a}, 8'h0E);
    chk("t1 c3 seg", seg_a, 8'hC0);

    // 1234 visible after the frame boundary
    drive_load(16'h1234, 4'h0);
    wait_fs(0, "t2 fs");
    chk("t2 d0 sel", {4'h0, sel_a}, 8'h0E);
    chk("t2 d0 seg", seg_a, 8'h99);
    skip(24);
    chk("t2 d3 sel", {4'h0, sel_a}, 8'h07);
    chk("t2 d3 seg", seg_a, 8'hF9);
    skip(6);
    chk("t2 gap sel", {4'h0, sel_a}, 8'h0F);
    chk("t2 gap seg", seg_a, 8'hFF);

    // leading-zero blanking of 00A0
    @(negedge clk); lz_blank = 1'b1;
    drive_load(16'h00A0, 4'h0);
    wait_fs(0, "t3 fs");
    chk("t3 d0 seg", seg_a, 8'hC0);
    skip(8);  chk("t3 d1 seg", seg_a, 8'h88);
    skip(8);  chk("t3 d2 seg", seg_a, 8'hFF);
    skip(8);  chk("t3 d3 seg", seg_a, 8'hFF);
    @(negedge clk); lz_blank = 1'b0;
    skip(1);
    chk("t3 d3 nolz sel", {4'h0, sel_a}, 8'h07);
    chk("t3 d3 nolz seg", seg_a, 8'hC0);

    // two loads in one frame: only the last one is shown, one swap
    skip(8);
    drive_load(16'hAAAA, 4'h0);
    repeat (2) @(negedge clk);
    drive_load(16'hBBBB, 4'h0);
    wait_fs(0, "t4 fs");
    chk("t4 d0 seg", seg_a, 8'h83);
    count_fs_a(2 * FRAME, c);
    chk("t4 extra fs", c[7:0], 8'h00);

    // load exactly on the frame_end cycle
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (m_t[0] % FRAME == FRAME - 1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL t5 sync: frame_end got none expected within %0d cycles", 2 * FRAME);
    end
    data = 16'hCCCC; dp = 4'h0; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_fs(0, "t5 fs");
    chk("t5 d0 seg", seg_a, 8'hC6);
    count_fs_a(2 * FRAME, c);
    chk("t5 second swap", c[7:0], 8'h00);

    // BLANK_CYC=0 instance with dp on digit 2
    drive_load(16'h5678, 4'b0100);
    wait_fs(1, "t6 fs");
    chk("t6 d0 sel", {4'h0, sel_b}, 8'h0E);
    chk("t6 d0 dp", {7'h0, seg_b[7]}, 8'h01);
    skip(16);
    chk("t6 d2 sel", {4'h0, sel_b}, 8'h0B);
    chk("t6 d2 dp", {7'h0, seg_b[7]}, 8'h00);
    c = 0;
    repeat (FRAME) begin
      @(posedge clk); #1;
      if (sel_b === 4'hF) c++;
    end
    chk("t6 idle cycles", c[7:0], 8'h00);

    // randomized traffic with one mid-scan reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst sel_a", {4'h0, sel_a}, 8'h0F);
        chk("rst seg_a", seg_a, 8'hFF);
        chk("rst fs_a", {7'h0, fs_a}, 8'h00);
        chk("rst sel_b", {4'h0, sel_b}, 8'h0F);
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end else begin
        data     = 16'($urandom);
        dp       = 4'($urandom);
        lz_blank = 1'($urandom_range(0, 1));
        load     = ($urandom_range(0, 15) == 0);
      end
    end
    @(negedge clk); load = 1'b0;
    skip(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
